// File: rtl/serial_bus_pkg.sv
// Shared definitions for the serial bus: FSM state encodings and frame/response
// bit values used by the slave endpoint.
package serial_bus_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic START_BIT = 1'b1;
  localparam logic ACK       = 1'b1;
  localparam logic NACK      = 1'b0;
  localparam logic RW_WRITE  = 1'b1;

  // Encodings are visible on state_o and must stay fixed.
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_RW        = 4'd1,
    ST_ADDR      = 4'd2,
    ST_DATA      = 4'd3,
    ST_PARITY    = 4'd4,
    ST_DECIDE    = 4'd5,
    ST_RSP_START = 4'd6,
    ST_RSP_ACK   = 4'd7,
    ST_RSP_DATA  = 4'd8
  } state_t;

endpackage

// File: rtl/sbus_shift_reg.sv
// LSB-first shift register: parallel load, serial shift-in at the MSB end;
// q[0] is the serial output bit.
module sbus_shift_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] ld_val,
  input  logic         shift,
  input  logic         sin,
  output logic [W-1:0] q
);

  generate
    if (W == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (rst)        q <= '0;
        else if (load)  q <= ld_val;
        else if (shift) q <= sin;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (rst)        q <= '0;
        else if (load)  q <= ld_val;
        else if (shift) q <= {sin, q[W-1:1]};
      end
    end
  endgenerate

endmodule

// File: rtl/serial_slave_port.sv
// Bit-serial slave endpoint: decodes a request frame on rx, accesses a local
// register file and returns ACK/NACK (+ read data) on tx. Optional: SLAVE_PARITY_EN.
module serial_slave_port
  import serial_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rx,
  output logic              tx,
  input  logic              busy,
  output logic [DATA_W-1:0] wdata,
  output logic              wr_strobe,
  output logic [3:0]        state_o
);

  localparam int unsigned CNT_W = ($clog2(ADDR_W) > 3) ? $clog2(ADDR_W) : 3;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(DATA_W - 1);

`ifdef SLAVE_PARITY_EN
  localparam state_t AFTER_FIELDS = ST_PARITY;
`else
  localparam state_t AFTER_FIELDS = ST_DECIDE;
`endif

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                rw_q;
  logic                ack_q;
  logic                ack_now;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                addr_shift;
  logic                data_shift;
  logic                data_sin;
  logic                data_load;
  logic [DATA_W-1:0]   data_ld_val;

  // The data register doubles as rx capture and tx serialiser: it is cleared at
  // each start bit, filled during DATA, reloaded with read data in DECIDE.
  always_comb begin
    addr_shift  = (state == ST_ADDR);
    data_shift  = (state == ST_DATA) || (state == ST_RSP_DATA);
    data_sin    = (state == ST_DATA) ? rx : 1'b0;
    data_load   = ((state == ST_IDLE) && (rx == START_BIT)) ||
                  ((state == ST_DECIDE) && (rw_q != RW_WRITE) && (ack_now == ACK));
    data_ld_val = (state == ST_DECIDE) ? mem[addr_q] : '0;
  end

  sbus_shift_reg #(.W(ADDR_W)) u_addr_sr (
    .clk    (clk),
    .rst    (rstn),
    .load   (1'b0),
    .ld_val ('0),
    .shift  (addr_shift),
    .sin    (rx),
    .q      (addr_q)
  );

  sbus_shift_reg #(.W(DATA_W)) u_data_sr (
    .clk    (clk),
    .rst    (rstn),
    .load   (data_load),
    .ld_val (data_ld_val),
    .shift  (data_shift),
    .sin    (data_sin),
    .q      (data_q)
  );

`ifdef SLAVE_PARITY_EN
  logic par_q;
  logic parity_ok;

  always_ff @(posedge clk) begin
    if (rstn)                     par_q <= 1'b0;
    else if (state == ST_PARITY)  par_q <= rx;
  end

  // Even parity: rw, addr, data and the parity bit together hold an even number of ones.
  assign parity_ok = ~^{rw_q, addr_q, data_q, par_q};
  assign ack_now   = (!busy && parity_ok) ? ACK : NACK;
`else
  assign ack_now   = busy ? NACK : ACK;
`endif

  always_ff @(posedge clk) begin
    if (rstn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rw_q      <= 1'b0;
      ack_q     <= 1'b0;
      wdata     <= '0;
      wr_strobe <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (rx == START_BIT) state <= ST_RW;
        end
        ST_RW: begin
          rw_q  <= rx;
          state <= ST_ADDR;
        end
        ST_ADDR: begin
          if (cnt == ADDR_LAST) begin
            cnt   <= '0;
            state <= (rw_q == RW_WRITE) ? ST_DATA : AFTER_FIELDS;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == BYTE_LAST) begin
            cnt   <= '0;
            state <= AFTER_FIELDS;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_PARITY: state <= ST_DECIDE;
        ST_DECIDE: begin
          ack_q <= ack_now;
          if ((rw_q == RW_WRITE) && (ack_now == ACK)) begin
            mem[addr_q] <= data_q;
            wdata       <= data_q;
            wr_strobe   <= 1'b1;
          end
          state <= ST_RSP_START;
        end
        ST_RSP_START: state <= ST_RSP_ACK;
        ST_RSP_ACK: begin
          cnt   <= '0;
          state <= ((rw_q != RW_WRITE) && (ack_q == ACK)) ? ST_RSP_DATA : ST_IDLE;
        end
        ST_RSP_DATA: begin
          if (cnt == BYTE_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    tx = 1'b0;
    case (state)
      ST_RSP_START: tx = START_BIT;
      ST_RSP_ACK:   tx = ack_q;
      ST_RSP_DATA:  tx = data_q[0];
      default:      tx = 1'b0;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_serial_slave_port.sv
// Self-checking bench for serial_slave_port: directed vector table, reset and
// back-to-back sequences, then random frames against an array-based memory model.
module tb_serial_slave_port;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rx;
  logic       tx;
  logic       busy;
  logic [7:0] wdata;
  logic       wr_strobe;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  serial_slave_port #(.ADDR_W(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rx        (rx),
    .tx        (tx),
    .busy      (busy),
    .wdata     (wdata),
    .wr_strobe (wr_strobe),
    .state_o   (state_o)
  );

  int checks     = 0;
  int errors     = 0;
  int strobe_cnt = 0;
  int exp_writes = 0;

  logic [7:0] model_mem [16];
  logic [7:0] model_wdata;

  typedef struct {
    logic       rw;
    logic [3:0] addr;
    logic [7:0] data;
    logic       busy;
    logic       bad_par;
    logic       exp_ack;
    logic [7:0] exp_rdata;
    logic       exp_strobe;
    logic [7:0] exp_wdata;
  } vec_t;

  vec_t vecs[$];

  always @(negedge clk) if (wr_strobe === 1'b1) strobe_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic rw, input logic [3:0] addr, input logic [7:0] data,
                         input logic bsy, input logic bad_par, input logic exp_ack,
                         input logic [7:0] exp_rdata, input logic exp_strobe,
                         input logic [7:0] exp_wdata);
    vec_t v;
    v.rw = rw; v.addr = addr; v.data = data; v.busy = bsy; v.bad_par = bad_par;
    v.exp_ack = exp_ack; v.exp_rdata = exp_rdata; v.exp_strobe = exp_strobe;
    v.exp_wdata = exp_wdata;
    vecs.push_back(v);
  endtask

  // Reference behaviour: ack unless busy or corrupted parity; acked writes update memory.
  task automatic model_apply(input logic rw, input logic [3:0] addr, input logic [7:0] data,
                             input logic bsy, input logic bad_par,
                             output logic ack, output logic [7:0] rdata,
                             output logic strobe, output logic [7:0] wd);
    ack    = !bsy && !bad_par;
    rdata  = model_mem[addr];
    strobe = rw && ack;
    if (strobe) begin
      model_mem[addr] = data;
      model_wdata     = data;
      exp_writes++;
    end
    wd = model_wdata;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    model_wdata = 8'h00;
  endtask

  // Drives one frame starting in an IDLE cycle and checks the full response.
  task automatic run_frame(input logic rw, input logic [3:0] addr, input logic [7:0] data,
                           input logic busy_dec, input logic bad_par,
                           input logic exp_ack, input logic [7:0] exp_rdata,
                           input logic exp_strobe, input logic [7:0] exp_wdata);
    logic bits[$];
    int   n_rsp;
    logic exp_bit;
    bits.push_back(1'b1);
    bits.push_back(rw);
    for (int i = 0; i < 4; i++) bits.push_back(addr[i]);
    if (rw) for (int i = 0; i < 8; i++) bits.push_back(data[i]);
`ifdef SLAVE_PARITY_EN
    bits.push_back((^{rw, addr, (rw ? data : 8'h00)}) ^ bad_par);
`endif
    for (int i = 0; i < bits.size(); i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("idle_state", 32'(state_o), 32'd0);
        check("idle_tx", 32'(tx), 32'd0);
      end
      rx   = bits[i];
      busy = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    check("decide_state", 32'(state_o), 32'd5);
    rx   = 1'b0;
    busy = busy_dec;
    n_rsp = (!rw && exp_ack) ? 10 : 2;
    for (int j = 0; j < n_rsp; j++) begin
      @(negedge clk);
      if (j == 0)      exp_bit = 1'b1;
      else if (j == 1) exp_bit = exp_ack;
      else             exp_bit = exp_rdata[j-2];
      check($sformatf("rsp_bit%0d", j), 32'(tx), 32'(exp_bit));
      check("wr_strobe", 32'(wr_strobe), 32'((j == 0) ? exp_strobe : 1'b0));
      busy = 1'($urandom_range(0, 1));
      rx   = (j == n_rsp - 1) ? 1'b0 : 1'($urandom_range(0, 1));
    end
    check("wdata", 32'(wdata), 32'(exp_wdata));
  endtask

  initial begin
    logic       m_ack;
    logic [7:0] m_rdata;
    logic       m_strobe;
    logic [7:0] m_wd;
    int         base;

    rstn = 1'b1;
    rx   = 1'b0;
    busy = 1'b0;
    model_clear();

    add_vec(1'b1, 4'd3,  8'hA5, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'hA5);
    add_vec(1'b0, 4'd3,  8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 8'hA5);
    add_vec(1'b1, 4'd5,  8'h3C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'hA5);
    add_vec(1'b0, 4'd5,  8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'hA5);
    add_vec(1'b0, 4'd3,  8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'hA5);
    add_vec(1'b1, 4'd15, 8'h81, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h81);
    add_vec(1'b1, 4'd0,  8'h7E, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h7E);
    add_vec(1'b0, 4'd15, 8'h00, 1'b0, 1'b0, 1'b1, 8'h81, 1'b0, 8'h7E);
    add_vec(1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 1'b1, 8'h7E, 1'b0, 8'h7E);
`ifdef SLAVE_PARITY_EN
    add_vec(1'b1, 4'd1,  8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h7E);
    add_vec(1'b1, 4'd1,  8'hFF, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'hFF);
    add_vec(1'b0, 4'd1,  8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 8'hFF);
    add_vec(1'b0, 4'd1,  8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'hFF);
`endif

    repeat (3) @(negedge clk);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_tx", 32'(tx), 32'd0);
    check("rst_wdata", 32'(wdata), 32'h00);
    check("rst_strobe", 32'(wr_strobe), 32'd0);
    rstn = 1'b0;

    foreach (vecs[k]) begin
      model_apply(vecs[k].rw, vecs[k].addr, vecs[k].data, vecs[k].busy, vecs[k].bad_par,
                  m_ack, m_rdata, m_strobe, m_wd);
      run_frame(vecs[k].rw, vecs[k].addr, vecs[k].data, vecs[k].busy, vecs[k].bad_par,
                vecs[k].exp_ack, vecs[k].exp_rdata, vecs[k].exp_strobe, vecs[k].exp_wdata);
    end

    // Abort a write to addr 3 in the middle of its DATA field with reset.
    begin
      logic partial[$];
      partial = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < partial.size(); i++) begin
        @(negedge clk);
        rx = partial[i];
      end
    end
    @(negedge clk);
    check("mid_data_state", 32'(state_o), 32'd3);
    rx   = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_state", 32'(state_o), 32'd0);
    check("post_rst_tx", 32'(tx), 32'd0);
    check("post_rst_wdata", 32'(wdata), 32'h00);
    rstn = 1'b0;
    model_clear();
    model_apply(1'b0, 4'd3, 8'h00, 1'b0, 1'b0, m_ack, m_rdata, m_strobe, m_wd);
    run_frame(1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);

    // Two writes with the second start bit right after the first response.
    base = strobe_cnt;
    model_apply(1'b1, 4'd9, 8'h5B, 1'b0, 1'b0, m_ack, m_rdata, m_strobe, m_wd);
    run_frame(1'b1, 4'd9, 8'h5B, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h5B);
    model_apply(1'b1, 4'd10, 8'hC3, 1'b0, 1'b0, m_ack, m_rdata, m_strobe, m_wd);
    run_frame(1'b1, 4'd10, 8'hC3, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'hC3);
    check("b2b_strobes", 32'(strobe_cnt - base), 32'd2);
    model_apply(1'b0, 4'd9, 8'h00, 1'b0, 1'b0, m_ack, m_rdata, m_strobe, m_wd);
    run_frame(1'b0, 4'd9, 8'h00, 1'b0, 1'b0, 1'b1, 8'h5B, 1'b0, 8'hC3);

    for (int n = 0; n < 60; n++) begin
      logic       r_rw;
      logic [3:0] r_addr;
      logic [7:0] r_data;
      logic       r_busy;
      logic       r_bad;
      r_rw   = 1'($urandom_range(0, 1));
      r_addr = 4'($urandom_range(0, 15));
      r_data = 8'($urandom_range(0, 255));
      r_busy = ($urandom_range(0, 3) == 0);
`ifdef SLAVE_PARITY_EN
      r_bad  = ($urandom_range(0, 3) == 0);
`else
      r_bad  = 1'b0;
`endif
      model_apply(r_rw, r_addr, r_data, r_busy, r_bad, m_ack, m_rdata, m_strobe, m_wd);
      run_frame(r_rw, r_addr, r_data, r_busy, r_bad, m_ack, m_rdata, m_strobe, m_wd);
      if ((n % 3) == 0) repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    @(negedge clk);
    check("total_strobes", 32'(strobe_cnt), 32'(exp_writes));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
